serdesphy_ana_pll_pfd: RTL
==========================

SERDESPHY_ANA_PLL_PFD -- requirements
Module: serdesphy_ana_pll_pfd

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth per input, minimum 2.
REQ-002 Parameter LOCK_WIN, default 2: maximum |phase_err| in cycles that counts as an in-window comparison.
REQ-003 Parameter LOCK_CNT, default 4: consecutive in-window comparisons required to assert lock, range 1..15.
REQ-004 clk  in  1  sampling clock for all logic.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 enable  in  1  enables detection; 0 forces idle.
REQ-007 ref_clk_in  in  1  reference clock, asynchronous to clk.
REQ-008 fb_clk_in  in  1  divided VCO feedback clock, asynchronous to clk.
REQ-009 up_pulse  out  1  registered UP drive to the charge pump.
REQ-010 down_pulse  out  1  registered DOWN drive to the charge pump.
REQ-011 phase_err  out  8  signed two's complement width of the last completed pulse; positive means UP.
REQ-012 err_valid  out  1  one-cycle strobe that marks a new phase_err.
REQ-013 lock  out  1  lock indicator.
REQ-014 slip_cnt  out  8  saturating count of cycle slips.

Function
REQ-015 Each clock input SHALL pass through SYNC_STAGES flops, then a previous-value flop; edge = synced & ~prev.
REQ-016 Latency: up_pulse/down_pulse SHALL assert SYNC_STAGES clk edges after the edge at which the first synchronizer flop captures 1.
REQ-017 FSM states IDLE, UP, DOWN; up_pulse = (state==UP), down_pulse = (state==DOWN), both never 1 together.
REQ-018 IDLE transitions: ref edge only -> UP; fb edge only -> DOWN; both edges -> stay IDLE and complete a comparison with width 0.
REQ-019 UP: fb edge (with or without ref edge) -> IDLE and complete with +width; ref edge without fb edge -> stay UP, slip event, width keeps counting.
REQ-020 DOWN SHALL mirror UP: ref edge -> IDLE with -width; a second fb edge without ref edge is a slip event.
REQ-021 Width counter SHALL load 1 on entry to UP/DOWN, increment each cycle in state, and saturate at 127, so the reported width equals the cycles the pulse was high.
REQ-022 phase_err and err_valid SHALL update on the same clk edge the FSM returns to IDLE; err_valid is high for exactly one cycle; phase_err holds until the next completion.
REQ-023 slip_cnt SHALL increment by 1 per slip event and saturate at 255; only rst clears it.
REQ-024 The good counter (4-bit) SHALL update one cycle after err_valid: if |phase_err| <= LOCK_WIN, increment saturating at LOCK_CNT; otherwise clear.
REQ-025 lock SHALL assert on the cycle the good counter reaches LOCK_CNT.
REQ-026 Out-of-window completion or any slip event SHALL clear the good counter and deassert lock on the same edge as that counter update.
REQ-027 enable=0: state forced IDLE and pulses low on the next edge; width and good counters cleared; lock cleared; no err_valid; slip_cnt and phase_err held.
REQ-028 Synchronizers and prev flops SHALL run while enable=0, so re-enabling creates no false edge.

Reset
REQ-029 On rst high at a clk edge: state IDLE, up_pulse/down_pulse/err_valid/lock 0, phase_err 0, slip_cnt 0, all counters 0, all synchronizer and prev flops 0.
REQ-030 Reset applied mid-pulse SHALL abort the pulse on that edge with no err_valid.
REQ-031 An input held high through reset release SHALL produce exactly one edge.

Structure
REQ-032 Package serdesphy_pll_pkg SHALL hold the FSM state enum, PFD_ERR_W=8, PFD_WIDTH_MAX=127 and SLIP_CNT_W=8.
REQ-033 Sub-module serdesphy_pll_edge_sync (synchronizer plus rising-edge detect) SHALL be instantiated once per input.

Verification (SYNC_STAGES=2, LOCK_WIN=2, LOCK_CNT=4)
REQ-034 Ref rising edge, fb rising edge 5 clk later -> up_pulse high 5 cycles, phase_err=+5, err_valid one cycle.
REQ-035 Fb leads ref by 3 clk -> down_pulse high 3 cycles, phase_err=0xFD (-3).
REQ-036 Two ref edges with no fb edge between -> slip_cnt=1, lock=0, up_pulse stays high.
REQ-037 Four completions with |err|<=2 -> lock=1 one cycle after the 4th err_valid; next err=+6 -> lock=0 one cycle after that err_valid.
REQ-038 Simultaneous edges in IDLE -> no pulse, err_valid=1, phase_err=0.
REQ-039 rst asserted 2 cycles into UP -> all outputs 0 on the next cycle, no err_valid.

Source files
------------

// File: rtl/serdesphy_pll_pkg.sv
// Shared constants and state type for the PLL phase-frequency detector.
package serdesphy_pll_pkg;

    localparam int unsigned PFD_ERR_W     = 8;
    localparam int unsigned PFD_WIDTH_MAX = 127;
    localparam int unsigned PFD_WIDTH_W   = 7;
    localparam int unsigned SLIP_CNT_W    = 8;
    localparam int unsigned GOOD_CNT_W    = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StUp   = 2'd1,
        StDown = 2'd2
    } pfd_state_e;

endpackage

// File: rtl/serdesphy_pll_edge_sync.sv
// Multi-flop synchronizer for an asynchronous clock input followed by rising-edge detection.
module serdesphy_pll_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/serdesphy_ana_pll_pfd.sv
// Digital PFD: compares synchronized ref/fb edges, drives UP/DOWN pulses, reports signed pulse
// width, counts cycle slips and raises lock after a run of in-window comparisons.
module serdesphy_ana_pll_pfd
    import serdesphy_pll_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_WIN    = 2,
    parameter int unsigned LOCK_CNT    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  ref_clk_in,
    input  logic                  fb_clk_in,
    output logic                  up_pulse,
    output logic                  down_pulse,
    output logic [PFD_ERR_W-1:0]  phase_err,
    output logic                  err_valid,
    output logic                  lock,
    output logic [SLIP_CNT_W-1:0] slip_cnt
);

    localparam logic [PFD_WIDTH_W-1:0] WidthMax = PFD_WIDTH_W'(PFD_WIDTH_MAX);
    localparam logic [GOOD_CNT_W-1:0]  GoodMax  = GOOD_CNT_W'(LOCK_CNT);
    localparam logic [PFD_ERR_W-1:0]   WinMax   = PFD_ERR_W'(LOCK_WIN);

    logic ref_edge;
    logic fb_edge;

    // Synchronizers stay live regardless of enable so re-enabling never sees a stale edge.
    serdesphy_pll_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ref_sync (
        .clk     (clk),
        .rst     (rst),
        .async_in(ref_clk_in),
        .rise    (ref_edge)
    );

    serdesphy_pll_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_fb_sync (
        .clk     (clk),
        .rst     (rst),
        .async_in(fb_clk_in),
        .rise    (fb_edge)
    );

    pfd_state_e             state_q, state_d;
    logic [PFD_WIDTH_W-1:0] width_q, width_d, width_inc;
    logic                   done, slip, slip_q;
    logic [PFD_ERR_W-1:0]   done_err, err_abs;
    logic [GOOD_CNT_W-1:0]  good_q, good_d;

    assign width_inc = (width_q == WidthMax) ? width_q : width_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        done     = 1'b0;
        slip     = 1'b0;
        done_err = '0;
        unique case (state_q)
            StIdle: begin
                if (ref_edge && fb_edge) begin
                    done = 1'b1;
                end else if (ref_edge) begin
                    state_d = StUp;
                    width_d = PFD_WIDTH_W'(1);
                end else if (fb_edge) begin
                    state_d = StDown;
                    width_d = PFD_WIDTH_W'(1);
                end
            end
            StUp: begin
                if (fb_edge) begin
                    state_d  = StIdle;
                    width_d  = '0;
                    done     = 1'b1;
                    done_err = {1'b0, width_q};
                end else begin
                    slip    = ref_edge;
                    width_d = width_inc;
                end
            end
            StDown: begin
                if (ref_edge) begin
                    state_d  = StIdle;
                    width_d  = '0;
                    done     = 1'b1;
                    done_err = PFD_ERR_W'(0) - {1'b0, width_q};
                end else begin
                    slip    = fb_edge;
                    width_d = width_inc;
                end
            end
            default: begin
                state_d = StIdle;
                width_d = '0;
            end
        endcase
        if (!enable) begin
            state_d = StIdle;
            width_d = '0;
            done    = 1'b0;
            slip    = 1'b0;
        end
    end

    assign err_abs = phase_err[PFD_ERR_W-1] ? PFD_ERR_W'(0) - phase_err : phase_err;

    // Lock qualification trails the completion strobe by one cycle; a slip resets it outright.
    always_comb begin
        good_d = good_q;
        if (!enable || slip_q) begin
            good_d = '0;
        end else if (err_valid) begin
            if (err_abs <= WinMax) begin
                good_d = (good_q >= GoodMax) ? GoodMax : good_q + 1'b1;
            end else begin
                good_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            width_q   <= '0;
            phase_err <= '0;
            err_valid <= 1'b0;
            slip_q    <= 1'b0;
            slip_cnt  <= '0;
            good_q    <= '0;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            err_valid <= done;
            slip_q    <= slip;
            good_q    <= good_d;
            if (done) begin
                phase_err <= done_err;
            end
            if (slip && (slip_cnt != '1)) begin
                slip_cnt <= slip_cnt + 1'b1;
            end
        end
    end

    assign up_pulse   = (state_q == StUp);
    assign down_pulse = (state_q == StDown);
    assign lock       = (good_q == GoodMax);

endmodule
